// File: rtl/muu_value_set512.sv
// muu_value_set512 -- value-write stage of the muu pipeline.
//
// Accepts a request descriptor plus the matching 512-bit value stream. Write
// opcodes (SETCUR / SETNEXT / FLIPPOINT with len != 0) are split into burst
// write commands of at most MAX_BURST beats, each followed by its data beats.
// When the whole value has reached the store, the descriptor is forwarded
// downstream. Every other descriptor passes straight through.
//
// A stream that ends early is padded with zero beats. A stream that runs long
// is drained. Both cases flag output_error.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   input_data/valid/ready            descriptor in (ready is a 1-cycle pulse)
//   value_data/valid/last/ready       value stream in
//   wr_cmd_addr/beats/valid/ready     burst write command out
//   wr_data/valid/ready               write data beats out
//   output_data/error/valid/ready     descriptor out with error flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a descriptor
// ST_CMD   | presenting a burst command
// ST_DATA  | moving value beats into the write data register
// ST_PAD   | stream ended early, emitting zero beats
// ST_DRAIN | stream ran long, discarding beats through value_last
// ST_FLUSH | waiting for the final write beat to be taken
// ST_DONE  | presenting the descriptor downstream

module muu_value_set512 #(
    parameter int KEY_WIDTH    = 128,
    parameter int HEADER_WIDTH = 42,
    parameter int META_WIDTH   = 96,
    parameter int MEMORY_WIDTH = 512,
    parameter int MAX_BURST    = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [KEY_WIDTH+HEADER_WIDTH+META_WIDTH-1:0] input_data,
    input  logic                                        input_valid,
    output logic                                        input_ready,
    input  logic [MEMORY_WIDTH-1:0]                     value_data,
    input  logic                                        value_valid,
    input  logic                                        value_last,
    output logic                                        value_ready,
    output logic [31:0]                                 wr_cmd_addr,
    output logic [7:0]                                  wr_cmd_beats,
    output logic                                        wr_cmd_valid,
    input  logic                                        wr_cmd_ready,
    output logic [MEMORY_WIDTH-1:0]                     wr_data,
    output logic                                        wr_data_valid,
    input  logic                                        wr_data_ready,
    output logic [KEY_WIDTH+HEADER_WIDTH+META_WIDTH-1:0] output_data,
    output logic                                        output_error,
    output logic                                        output_valid,
    input  logic                                        output_ready
);

    localparam int DESC_W   = KEY_WIDTH + HEADER_WIDTH + META_WIDTH;
    localparam int ADDR_LSB = KEY_WIDTH + META_WIDTH;
    localparam int LEN_LSB  = ADDR_LSB + 32;
    localparam int OP_LSB   = KEY_WIDTH + META_WIDTH - 8;
    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    // Opcode values shared with the rest of the muu pipeline.
    localparam logic [3:0] HTOP_SETCUR    = 4'd1;
    localparam logic [3:0] HTOP_SETNEXT   = 4'd2;
    localparam logic [3:0] HTOP_FLIPPOINT = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_DATA, ST_PAD, ST_DRAIN, ST_FLUSH, ST_DONE
    } state_t;

    state_t             state;
    logic [DESC_W-1:0]  desc;
    logic               err;
    logic               pad;
    logic [31:0]        cur_addr;
    logic [7:0]         cmd_left;
    logic [7:0]         data_left;
    logic [7:0]         burst_cnt;

    logic [31:0] in_addr;
    logic [9:0]  in_len;
    logic [3:0]  in_op;
    logic [7:0]  in_beats;
    logic [7:0]  in_burst;
    logic [7:0]  next_burst;
    logic        in_write;
    logic        data_slot;

    assign in_addr    = input_data[ADDR_LSB +: 32];
    assign in_len     = input_data[LEN_LSB +: 10];
    assign in_op      = input_data[OP_LSB +: 4];
    // len is in 64-bit words; eight of them make one 512-bit beat.
    assign in_beats   = 8'((11'(in_len) + 11'd7) >> 3);
    assign in_burst   = (in_beats > MAX_B) ? MAX_B : in_beats;
    assign next_burst = (cmd_left > MAX_B) ? MAX_B : cmd_left;
    assign in_write   = ((in_op == HTOP_SETCUR) || (in_op == HTOP_SETNEXT) ||
                         (in_op == HTOP_FLIPPOINT)) && (in_len != 10'd0);

    assign data_slot   = !wr_data_valid || wr_data_ready;
    assign value_ready = ((state == ST_DATA) && data_slot) || (state == ST_DRAIN);
    assign output_data = desc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            desc          <= '0;
            err           <= 1'b0;
            pad           <= 1'b0;
            cur_addr      <= '0;
            cmd_left      <= '0;
            data_left     <= '0;
            burst_cnt     <= '0;
            input_ready   <= 1'b0;
            wr_cmd_addr   <= '0;
            wr_cmd_beats  <= '0;
            wr_cmd_valid  <= 1'b0;
            wr_data       <= '0;
            wr_data_valid <= 1'b0;
            output_error  <= 1'b0;
            output_valid  <= 1'b0;
        end else begin
            input_ready <= 1'b0;
            // The data register may drain in any state; a new load below wins.
            if (wr_data_valid && wr_data_ready) wr_data_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (input_valid && !output_valid) begin
                        desc        <= input_data;
                        input_ready <= 1'b1;
                        err         <= 1'b0;
                        pad         <= 1'b0;
                        if (in_write) begin
                            cur_addr     <= in_addr;
                            cmd_left     <= in_beats;
                            data_left    <= in_beats;
                            wr_cmd_valid <= 1'b1;
                            wr_cmd_addr  <= in_addr;
                            wr_cmd_beats <= in_burst;
                            state        <= ST_CMD;
                        end else begin
                            output_valid <= 1'b1;
                            output_error <= 1'b0;
                            state        <= ST_DONE;
                        end
                    end
                end

                ST_CMD: begin
                    if (wr_cmd_ready) begin
                        wr_cmd_valid <= 1'b0;
                        cur_addr     <= cur_addr + 32'(wr_cmd_beats);
                        cmd_left     <= cmd_left - wr_cmd_beats;
                        burst_cnt    <= wr_cmd_beats;
                        state        <= pad ? ST_PAD : ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (value_valid && value_ready) begin
                        wr_data       <= value_data;
                        wr_data_valid <= 1'b1;
                        burst_cnt     <= burst_cnt - 8'd1;
                        data_left     <= data_left - 8'd1;
                        if (data_left == 8'd1) begin
                            if (value_last) begin
                                state <= ST_FLUSH;
                            end else begin
                                err   <= 1'b1;
                                state <= ST_DRAIN;
                            end
                        end else if (value_last) begin
                            err   <= 1'b1;
                            pad   <= 1'b1;
                            state <= ST_PAD;
                        end else if (burst_cnt == 8'd1) begin
                            wr_cmd_valid <= 1'b1;
                            wr_cmd_addr  <= cur_addr;
                            wr_cmd_beats <= next_burst;
                            state        <= ST_CMD;
                        end
                    end
                end

                ST_PAD: begin
                    // burst_cnt is zero here only when the short stream ended
                    // exactly on a burst boundary.
                    if (burst_cnt == 8'd0) begin
                        wr_cmd_valid <= 1'b1;
                        wr_cmd_addr  <= cur_addr;
                        wr_cmd_beats <= next_burst;
                        state        <= ST_CMD;
                    end else if (data_slot) begin
                        wr_data       <= '0;
                        wr_data_valid <= 1'b1;
                        burst_cnt     <= burst_cnt - 8'd1;
                        data_left     <= data_left - 8'd1;
                        if (data_left == 8'd1) begin
                            state <= ST_FLUSH;
                        end else if (burst_cnt == 8'd1) begin
                            wr_cmd_valid <= 1'b1;
                            wr_cmd_addr  <= cur_addr;
                            wr_cmd_beats <= next_burst;
                            state        <= ST_CMD;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (value_valid && value_last) state <= ST_FLUSH;
                end

                ST_FLUSH: begin
                    if (!wr_data_valid) begin
                        output_valid <= 1'b1;
                        output_error <= err;
                        state        <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (output_ready) begin
                        output_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muu_value_set512.sv
// Testbench for muu_value_set512 (instantiated with MAX_BURST=4).
// Directed cases, then randomized descriptors/streams/stalls, each checked
// against a reference model built from the command/data/error rules.

module tb_muu_value_set512;

    localparam int KW = 128, HW = 42, MW = 96, DW = 512, MB = 4;
    localparam int DESC_W = KW + HW + MW;
    localparam logic [3:0] OP_GET = 4'd0, OP_SETCUR = 4'd1, OP_SETNEXT = 4'd2, OP_FLIP = 4'd3;

    logic              clk = 1'b0;
    logic              rst;
    logic [DESC_W-1:0] input_data;
    logic              input_valid, input_ready;
    logic [DW-1:0]     value_data;
    logic              value_valid, value_last, value_ready;
    logic [31:0]       wr_cmd_addr;
    logic [7:0]        wr_cmd_beats;
    logic              wr_cmd_valid, wr_cmd_ready;
    logic [DW-1:0]     wr_data;
    logic              wr_data_valid, wr_data_ready;
    logic [DESC_W-1:0] output_data;
    logic              output_error, output_valid, output_ready;

    muu_value_set512 #(
        .KEY_WIDTH(KW), .HEADER_WIDTH(HW), .META_WIDTH(MW),
        .MEMORY_WIDTH(DW), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .input_data(input_data), .input_valid(input_valid), .input_ready(input_ready),
        .value_data(value_data), .value_valid(value_valid), .value_last(value_last),
        .value_ready(value_ready),
        .wr_cmd_addr(wr_cmd_addr), .wr_cmd_beats(wr_cmd_beats),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .output_data(output_data), .output_error(output_error),
        .output_valid(output_valid), .output_ready(output_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Entered and left just after a rising edge. abort_at>0 asserts rst once
    // that many value beats have been taken while value_ready is high.
    task automatic run_txn(input logic [3:0] op, input logic [9:0] len, input logic [31:0] addr,
                           input int n, input bit rnd, input int abort_at);
        logic [DESC_W-1:0] desc;
        logic [DW-1:0]     stream[$];
        logic [DW-1:0]     exp_data[$];
        logic [DW-1:0]     got_data[$];
        logic [39:0]       exp_cmd[$];
        logic [39:0]       got_cmd[$];
        logic [39:0]       held_cmd;
        logic [DW-1:0]     held_data;
        logic [DESC_W:0]   held_out;
        bit  wr, exp_err, done, leak, cmd_stall, data_stall, out_stall;
        int  beats, vi, ir_cnt, ir_cyc;
        logic [31:0] a;
        int  rem, b;

        for (int i = 0; i < DESC_W / 32; i++) desc[i*32 +: 32] = $urandom;
        desc[KW+MW-8 +: 4] = op;
        desc[KW+MW +: 32]  = addr;
        desc[KW+MW+32 +: 10] = len;

        // Reference model
        wr    = (op == OP_SETCUR || op == OP_SETNEXT || op == OP_FLIP) && (len != 0);
        beats = (int'(len) + 7) / 8;
        for (int i = 0; i < n; i++) stream.push_back(rand_beat());
        exp_err = 1'b0;
        if (wr) begin
            a = addr;
            rem = beats;
            while (rem > 0) begin
                b = (rem < MB) ? rem : MB;
                exp_cmd.push_back({a, 8'(b)});
                a = a + 32'(b);
                rem -= b;
            end
            for (int i = 0; i < beats; i++) exp_data.push_back((i < n) ? stream[i] : '0);
            exp_err = (n != beats);
        end

        input_data  = desc;
        input_valid = 1'b1;
        vi = 0; ir_cnt = 0; ir_cyc = -1;
        done = 0; leak = 0; cmd_stall = 0; data_stall = 0; out_stall = 0;
        held_cmd = '0; held_data = '0; held_out = '0;

        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            wr_cmd_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            output_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (vi < n) begin
                value_valid = 1'b1;
                value_data  = stream[vi];
                value_last  = (vi == n - 1);
            end else begin
                value_valid = 1'b0;
                value_last  = 1'b0;
            end
            @(negedge clk);

            if (input_ready) begin
                ir_cnt++;
                if (ir_cyc < 0) begin
                    ir_cyc = cyc;
                    check("cmd_valid_at_accept", wr_cmd_valid, wr);
                    check("out_valid_at_accept", output_valid, !wr);
                end
            end
            if (cmd_stall) begin
                check("cmd_held_valid", wr_cmd_valid, 1);
                check("cmd_held_fields", {wr_cmd_addr, wr_cmd_beats}, held_cmd);
            end
            if (data_stall) begin
                check("data_held_valid", wr_data_valid, 1);
                check("data_held_value", wr_data, held_data);
            end
            if (out_stall) begin
                check("out_held_valid", output_valid, 1);
                check("out_held_fields", {output_error, output_data}, held_out);
            end
            cmd_stall  = wr_cmd_valid && !wr_cmd_ready;
            held_cmd   = {wr_cmd_addr, wr_cmd_beats};
            data_stall = wr_data_valid && !wr_data_ready;
            held_data  = wr_data;
            out_stall  = output_valid && !output_ready;
            held_out   = {output_error, output_data};

            if (wr_cmd_valid && wr_cmd_ready) got_cmd.push_back({wr_cmd_addr, wr_cmd_beats});
            if (wr_data_valid && wr_data_ready) got_data.push_back(wr_data);
            if (value_valid && value_ready) vi++;
            if (!wr && (value_ready || wr_cmd_valid)) leak = 1;
            if (output_valid && output_ready) begin
                check("out_data", output_data, desc);
                check("out_error", output_error, exp_err);
                check("out_after_last_data", got_data.size(), exp_data.size());
                done = 1;
            end

            if (abort_at > 0 && vi >= abort_at && value_ready) begin
                rst = 1'b1;
                #1;
                check("rst_input_ready", input_ready, 0);
                check("rst_cmd_valid", wr_cmd_valid, 0);
                check("rst_data_valid", wr_data_valid, 0);
                check("rst_out_valid", output_valid, 0);
                check("rst_out_error", output_error, 0);
                check("rst_value_ready", value_ready, 0);
                input_valid = 1'b0;
                value_valid = 1'b0;
                value_last  = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end

            @(posedge clk);
            #1;
            if (ir_cnt > 0) input_valid = 1'b0;
        end
        input_valid = 1'b0;
        value_valid = 1'b0;
        value_last  = 1'b0;

        check("txn_completed", done, 1);
        check("accept_latency", ir_cyc, 1);
        check("accept_pulse_count", ir_cnt, 1);
        check("value_beats_taken", vi, n);
        if (!wr) check("passthru_quiet", leak, 0);
        check("cmd_count", got_cmd.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size() && i < got_cmd.size(); i++)
            check($sformatf("cmd%0d", i), got_cmd[i], exp_cmd[i]);
        check("data_count", got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++)
            check($sformatf("data%0d", i), got_data[i], exp_data[i]);
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [9:0]  r_len;
        int          r_beats, r_n;
        bit          r_wr;

        rst = 1'b1;
        input_valid = 1'b0; input_data = '0;
        value_valid = 1'b0; value_data = '0; value_last = 1'b0;
        wr_cmd_ready = 1'b0; wr_data_ready = 1'b0; output_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_input_ready", input_ready, 0);
        check("reset_cmd_valid", wr_cmd_valid, 0);
        check("reset_data_valid", wr_data_valid, 0);
        check("reset_out_valid", output_valid, 0);
        check("reset_out_error", output_error, 0);
        check("reset_value_ready", value_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_txn(OP_SETCUR,  10'd20, 32'h0000_0100, 3, 0, 0);   // basic write
        run_txn(OP_SETNEXT, 10'd40, 32'hFFFF_FFFE, 5, 0, 0);   // burst split + wrap
        run_txn(OP_GET,     10'd50, 32'h0000_1234, 0, 0, 0);   // pass-through
        run_txn(OP_FLIP,    10'd24, 32'h0000_000A, 1, 0, 0);   // short stream
        run_txn(OP_SETCUR,  10'd8,  32'h0000_0040, 3, 0, 0);   // long stream
        run_txn(OP_SETCUR,  10'd0,  32'h0000_0080, 0, 0, 0);   // zero length
        run_txn(OP_SETNEXT, 10'd64, 32'h0000_0500, 5, 1, 0);   // short across bursts

        for (int t = 0; t < 24; t++) begin
            r_op    = 4'($urandom_range(0, 5));
            r_len   = 10'($urandom_range(0, 90));
            r_wr    = (r_op == OP_SETCUR || r_op == OP_SETNEXT || r_op == OP_FLIP) && (r_len != 0);
            r_beats = (int'(r_len) + 7) / 8;
            r_n     = r_beats + int'($urandom_range(0, 4)) - 2;
            if (r_n < 1) r_n = 1;
            if (!r_wr) r_n = 0;
            run_txn(r_op, r_len, $urandom, r_n, 1, 0);
        end

        run_txn(OP_SETCUR,  10'd64, 32'h0000_2000, 8, 0, 2);   // reset mid-data
        run_txn(OP_SETNEXT, 10'd20, 32'h0000_0300, 3, 1, 0);   // recovery

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
